// File: rtl/ram_responder.sv
// Purpose : word-addressed 32-bit RAM model on the RAM end of cpu_ram; requests are level
//           signals (memREN/memWEN) that the controller holds until it sees ACCESS.
// Latency : a request first seen in cycle 0 gets ACCESS in cycle LAT+1 (LAT BUSY cycles in WAIT).
// Backpr. : ramstate BUSY stalls the requester; ERROR is combinational for any illegal request.
// Ports   : CLK, nRST (sync, active-low) | memaddr[AW], memstore[32], memREN, memWEN (requests)
//           ramload[32] (registered read data), ramstate[2] (FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//           rd_count[32], wr_count[32] only when RAM_RESPONDER_STATS_EN is defined.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4096,
  parameter int AW    = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [AW-1:0] memaddr,
  input  logic [31:0]   memstore,
  input  logic          memREN,
  input  logic          memWEN,
  output logic [31:0]   ramload,
  output logic [1:0]    ramstate
`ifdef RAM_RESPONDER_STATS_EN
  ,
  output logic [31:0]   rd_count,
  output logic [31:0]   wr_count
`endif
);

  localparam int IW = $clog2(DEPTH);
  // First byte address past the end of the array; one extra bit so DEPTH*4 never wraps.
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH) << 2;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] lat_addr;
  logic          lat_wr;

  logic          req;
  logic          illegal;
  logic          same_req;
  logic          mem_we;
  logic [IW-1:0] idx;
  logic [IW-1:0] lat_idx;

  assign req     = memREN | memWEN;
  assign idx     = memaddr[IW+1:2];
  assign lat_idx = lat_addr[IW+1:2];

  always_comb begin
    illegal = (memREN & memWEN)
            | (req & (memaddr[1:0] != 2'b00))
            | (req & ({1'b0, memaddr} >= LIMIT));
  end

  // The request is still the one that was latched when the access started.
  assign same_req = req & (memaddr == lat_addr) & (memWEN == lat_wr);

  // A write commits on the edge leaving DONE only if the controller is still driving it.
  assign mem_we = nRST & ~illegal & (state == S_DONE) & lat_wr & memWEN
                & (memaddr == lat_addr);

  always_comb begin
    ramstate = FREE;
    if (illegal) begin
      ramstate = ERROR;
    end else begin
      case (state)
        S_IDLE:  ramstate = req ? BUSY : FREE;
        S_WAIT:  ramstate = BUSY;
        S_DONE:  ramstate = ACCESS;
        default: ramstate = FREE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ramload  <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
    end else if (illegal) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_addr <= memaddr;
            lat_wr   <= memWEN;
            cnt      <= 4'(LAT);
            if (LAT == 0) begin
              state <= S_DONE;
              if (!memWEN) ramload <= mem[idx];
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!same_req) begin
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            state <= S_DONE;
            if (!lat_wr) ramload <= mem[lat_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset: contents survive nRST.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[lat_idx] <= memstore;
  end

`ifdef RAM_RESPONDER_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if ((state == S_DONE) && !illegal && !lat_wr) rd_count <= rd_count + 32'd1;
      if (mem_we) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  localparam int N     = 3;     // instances with LAT = 0, 2, 3
  localparam int DEPTH = 4096;
  localparam int MW    = 32;    // words touched by the bench

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, ren, wen;
  logic [31:0] addr, store;
  logic [1:0]  st [N];
  logic [31:0] ld [N];
`ifdef RAM_RESPONDER_STATS_EN
  logic [31:0] rdc [N];
  logic [31:0] wrc [N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_responder #(.LAT(g == 0 ? 0 : (g == 1 ? 2 : 3)), .DEPTH(DEPTH), .AW(32)) u (
      .CLK      (clk),
      .nRST     (nrst),
      .memaddr  (addr),
      .memstore (store),
      .memREN   (ren),
      .memWEN   (wen),
      .ramload  (ld[g]),
      .ramstate (st[g])
`ifdef RAM_RESPONDER_STATS_EN
      ,
      .rd_count (rdc[g]),
      .wr_count (wrc[g])
`endif
    );
  end

  function automatic int lat_of(int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: per instance, the number of cycles since the current access began
  // (0 = no access in progress, 1..LAT = waiting, LAT+1 = the ACCESS cycle).
  int          phase    [N];
  logic [31:0] req_addr [N];
  bit          req_wr   [N];
  logic [31:0] eload    [N];
  bit          eload_kn [N];
  logic [31:0] mm       [N][MW];
  bit          kn       [N][MW];
  int unsigned erd      [N];
  int unsigned ewr      [N];
  bit          model_chk = 1'b0;

  task automatic model_load(int i, logic [31:0] a);
    int w;
    w = int'(a >> 2);
    if (w < MW) begin
      eload[i]    = mm[i][w];
      eload_kn[i] = kn[i][w];
    end else begin
      eload_kn[i] = 1'b0;
    end
  endtask

  // Called mid-cycle: check outputs against the model, then advance it across the next edge.
  task automatic model_step();
    bit         rq, ill;
    int         lat, w;
    logic [1:0] est;
    rq  = ren | wen;
    ill = (ren && wen) || (rq && addr[1:0] != 2'b00) || (rq && addr >= 32'(DEPTH * 4));
    for (int i = 0; i < N; i++) begin
      lat = lat_of(i);
      if (ill)                 est = ERROR;
      else if (phase[i] == 0)  est = rq ? BUSY : FREE;
      else if (phase[i] <= lat) est = BUSY;
      else                     est = ACCESS;
      if (model_chk) begin
        check($sformatf("model ramstate lat%0d", lat), st[i], est);
        if (eload_kn[i]) check($sformatf("model ramload lat%0d", lat), ld[i], eload[i]);
`ifdef RAM_RESPONDER_STATS_EN
        check($sformatf("model rd_count lat%0d", lat), rdc[i], erd[i]);
        check($sformatf("model wr_count lat%0d", lat), wrc[i], ewr[i]);
`endif
      end
      if (!nrst) begin
        phase[i] = 0; eload[i] = '0; eload_kn[i] = 1'b1; erd[i] = 0; ewr[i] = 0;
      end else if (ill) begin
        phase[i] = 0;
      end else if (phase[i] == 0) begin
        if (rq) begin
          req_addr[i] = addr;
          req_wr[i]   = wen;
          phase[i]    = 1;
          if (lat == 0 && !wen) model_load(i, addr);
        end
      end else if (phase[i] <= lat) begin
        if (!rq || addr != req_addr[i] || wen != req_wr[i]) begin
          phase[i] = 0;
        end else begin
          phase[i]++;
          if (phase[i] == lat + 1 && !req_wr[i]) model_load(i, req_addr[i]);
        end
      end else begin
        if (req_wr[i]) begin
          if (wen && addr == req_addr[i]) begin
            w = int'(req_addr[i] >> 2);
            mm[i][w] = store;
            kn[i][w] = 1'b1;
            ewr[i]++;
          end
        end else begin
          erd[i]++;
        end
        phase[i] = 0;
      end
    end
  endtask

  task automatic cyc(bit n, bit r, bit w, logic [31:0] a, logic [31:0] s);
    @(negedge clk);
    nrst = n; ren = r; wen = w; addr = a; store = s;
    #2;
    model_step();
  endtask

  typedef struct {
    bit          n, r, w;
    logic [31:0] a, s;
    logic [1:0]  est;
    logic [31:0] eld;
  } vec_t;
  vec_t tbl[$];

  function automatic void row(bit n, bit r, bit w, logic [31:0] a, logic [31:0] s,
                              logic [1:0] e, logic [31:0] l);
    vec_t v;
    v.n = n; v.r = r; v.w = w; v.a = a; v.s = s; v.est = e; v.eld = l;
    tbl.push_back(v);
  endfunction

  // One full LAT=2 access: three BUSY cycles, then ACCESS.
  function automatic void acc2(bit r, bit w, logic [31:0] a, logic [31:0] s,
                               logic [31:0] lb, logic [31:0] la);
    for (int j = 0; j < 3; j++) row(1, r, w, a, s, BUSY, lb);
    row(1, r, w, a, s, ACCESS, la);
  endfunction

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] B = 32'h0BADF00D;
  localparam logic [31:0] E = 32'h11111111;

  bit          rr, rw;
  logic [31:0] ra, rs;
  int          sel;

  initial begin
    nrst = 1'b0; ren = 1'b0; wen = 1'b0; addr = '0; store = '0;
    for (int i = 0; i < N; i++) begin
      phase[i] = 0; eload[i] = '0; eload_kn[i] = 1'b0; erd[i] = 0; ewr[i] = 0;
      req_addr[i] = '0; req_wr[i] = 1'b0;
      for (int j = 0; j < MW; j++) begin mm[i][j] = '0; kn[i][j] = 1'b0; end
    end

    // Vectors for the LAT=2 instance.
    row(1, 0, 0, 0, 0, FREE, 0);                       // reset state
    acc2(0, 1, 32'h10, D, 0, 0);                       // write DEADBEEF
    acc2(1, 0, 32'h10, 0, 0, D);                       // read back right after the write
    row(1, 0, 0, 0, 0, FREE, D);
    row(1, 1, 1, 32'h10, 0, ERROR, D);                 // both requests
    row(1, 1, 0, 32'h6, 0, ERROR, D);                  // misaligned
    row(1, 0, 1, 32'h4000, 32'h55, ERROR, D);          // out of range
    row(1, 0, 1, 32'h12, 32'h55, ERROR, D);            // misaligned write into word 0x10
    acc2(1, 0, 32'h10, 0, D, D);                       // unchanged
    acc2(0, 1, 32'h20, B, D, D);
    acc2(0, 1, 32'h40, E, D, D);
    row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);           // abort: request dropped
    row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);
    row(1, 0, 0, 0, 0, BUSY, D);
    row(1, 0, 0, 0, 0, FREE, D);
    row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);           // abort: address changed
    row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);
    row(1, 0, 1, 32'h24, 32'h1234, BUSY, D);
    row(1, 0, 0, 0, 0, FREE, D);
    row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);           // abort: op changed
    row(1, 1, 0, 32'h20, 0, BUSY, D);
    row(1, 0, 0, 0, 0, FREE, D);
    for (int j = 0; j < 3; j++) row(1, 0, 1, 32'h20, 32'h1234, BUSY, D);
    row(1, 0, 0, 0, 0, ACCESS, D);                     // write dropped in DONE
    row(1, 0, 0, 0, 0, FREE, D);
    acc2(1, 0, 32'h20, 0, D, B);
    row(1, 0, 1, 32'h40, 32'h7777, BUSY, B);           // reset mid-WAIT
    row(0, 0, 1, 32'h40, 32'h7777, BUSY, B);
    row(1, 0, 0, 0, 0, FREE, 0);
    acc2(1, 0, 32'h40, 0, 0, E);
    acc2(1, 0, 32'h10, 0, E, D);
    for (int j = 0; j < 3; j++) row(1, 0, 1, 32'h40, 32'h9999, BUSY, D);
    row(0, 0, 1, 32'h40, 32'h9999, ACCESS, D);         // reset mid-DONE
    row(1, 0, 0, 0, 0, FREE, 0);
    acc2(1, 0, 32'h40, 0, 0, E);

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    model_chk = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].n, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].s);
      check($sformatf("tbl%0d ramstate", i), st[1], tbl[i].est);
      check($sformatf("tbl%0d ramload", i), ld[1], tbl[i].eld);
    end

    // LAT=0: a held read repeats with ACCESS every other cycle.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lat0 idle", st[0], FREE);
    cyc(1, 1, 0, 32'h4, 0); check("lat0 c0", st[0], BUSY);
    cyc(1, 1, 0, 32'h4, 0); check("lat0 c1", st[0], ACCESS);
    cyc(1, 1, 0, 32'h4, 0); check("lat0 c2", st[0], BUSY);
    cyc(1, 1, 0, 32'h4, 0); check("lat0 c3", st[0], ACCESS);
    cyc(1, 0, 0, 0, 0);

    // LAT=3: committed write, then two aborted writes to the same word.
    for (int j = 0; j < 4; j++) begin
      cyc(1, 0, 1, 32'h20, 32'hCAFE0020);
      check($sformatf("lat3 wr c%0d", j), st[2], BUSY);
    end
    cyc(1, 0, 1, 32'h20, 32'hCAFE0020); check("lat3 wr access", st[2], ACCESS);
    cyc(1, 0, 0, 0, 0);                 check("lat3 free", st[2], FREE);
    cyc(1, 0, 1, 32'h20, 32'h1234);     check("lat3 drop c0", st[2], BUSY);
    cyc(1, 0, 1, 32'h20, 32'h1234);     check("lat3 drop c1", st[2], BUSY);
    cyc(1, 0, 0, 0, 0);                 check("lat3 drop c2", st[2], BUSY);
    cyc(1, 0, 0, 0, 0);                 check("lat3 drop end", st[2], FREE);
    cyc(1, 0, 1, 32'h20, 32'h1234);     check("lat3 mv c0", st[2], BUSY);
    cyc(1, 0, 1, 32'h20, 32'h1234);     check("lat3 mv c1", st[2], BUSY);
    cyc(1, 0, 1, 32'h28, 32'h1234);     check("lat3 mv c2", st[2], BUSY);
    cyc(1, 0, 0, 0, 0);                 check("lat3 mv end", st[2], FREE);
    for (int j = 0; j < 4; j++) cyc(1, 1, 0, 32'h20, 0);
    cyc(1, 1, 0, 32'h20, 0);
    check("lat3 rd access", st[2], ACCESS);
    check("lat3 rd data", ld[2], 32'hCAFE0020);
    cyc(1, 0, 0, 0, 0);

`ifdef RAM_RESPONDER_STATS_EN
    cyc(0, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 4; c++)
        cyc(1, j >= 3, j < 3, 32'(j * 4), 32'hA000 + 32'(j));
      cyc(1, 0, 0, 0, 0);
    end
    check("stats wr_count", wrc[1], 32'd3);
    check("stats rd_count", rdc[1], 32'd5);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("stats wr after reset", wrc[1], 32'd0);
    check("stats rd after reset", rdc[1], 32'd0);
`endif

    // Randomized traffic against the model.
    rr = 1'b0; rw = 1'b0; ra = '0; rs = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        cyc(0, 0, 0, 0, 0);
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          sel = $urandom_range(0, 19);
          rs  = $urandom;
          ra  = 32'($urandom_range(0, MW - 1)) * 4;
          rr  = (sel >= 4 && sel <= 10) || sel == 18 || sel == 19;
          rw  = (sel >= 11 && sel <= 17) || sel == 18;
          if (sel == 19) begin
            if ($urandom_range(0, 1) == 0) ra = ra + 32'($urandom_range(1, 3));
            else ra = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
          end
        end
        cyc(1, rr, rw, ra, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
